// File: rtl/alu_issue_ctrl_if.sv
// Bundle of command, ALU-side and response signals for alu_issue_ctrl.
// rsp_zero exists only when ALU_ISSUE_ZFLAG_EN is defined.
interface alu_issue_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op_select;
  logic [2:0]  cmd_operation;
  logic [31:0] cmd_operand1;
  logic [31:0] cmd_operand2;
  logic        alu_enable;
  logic [2:0]  alu_op_select;
  logic [2:0]  alu_operation;
  logic [31:0] alu_input1;
  logic [31:0] alu_input2;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [15:0] done_count;
`ifdef ALU_ISSUE_ZFLAG_EN
  logic        rsp_zero;
`endif

  modport slave (
`ifdef ALU_ISSUE_ZFLAG_EN
    output rsp_zero,
`endif
    input  cmd_valid, cmd_op_select, cmd_operation, cmd_operand1, cmd_operand2,
    input  alu_result, rsp_ready,
    output cmd_ready, alu_enable, alu_op_select, alu_operation, alu_input1, alu_input2,
    output rsp_valid, rsp_data, done_count
  );

  modport master (
`ifdef ALU_ISSUE_ZFLAG_EN
    input  rsp_zero,
`endif
    output cmd_valid, cmd_op_select, cmd_operation, cmd_operand1, cmd_operand2,
    output alu_result, rsp_ready,
    input  cmd_ready, alu_enable, alu_op_select, alu_operation, alu_input1, alu_input2,
    input  rsp_valid, rsp_data, done_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to an external ALU, waits RESULT_LATENCY cycles, then holds the result
// until the consumer takes it. Optional zero flag on the response: define ALU_ISSUE_ZFLAG_EN.
module alu_issue_ctrl #(
  parameter int unsigned RESULT_LATENCY = 1
) (
  input logic             clock,
  input logic             reset,
  alu_issue_ctrl_if.slave bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_select_q, op_select_d;
  logic [2:0]          operation_q, operation_d;
  logic [DATA_W-1:0]   operand1_q, operand1_d;
  logic [DATA_W-1:0]   operand2_q, operand2_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [15:0]         done_count_q, done_count_d;
  logic                cmd_ready_c;
  logic                alu_enable_c;
  logic                rsp_valid_c;
`ifdef ALU_ISSUE_ZFLAG_EN
  logic                rsp_zero_q, rsp_zero_d;
`endif

  always_comb begin
    state_d      = state_q;
    op_select_d  = op_select_q;
    operation_d  = operation_q;
    operand1_d   = operand1_q;
    operand2_d   = operand2_q;
    wait_cnt_d   = wait_cnt_q;
    rsp_data_d   = rsp_data_q;
    done_count_d = done_count_q;
`ifdef ALU_ISSUE_ZFLAG_EN
    rsp_zero_d   = rsp_zero_q;
`endif
    cmd_ready_c  = 1'b0;
    alu_enable_c = 1'b0;
    rsp_valid_c  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          op_select_d = bus.cmd_op_select;
          operation_d = bus.cmd_operation;
          operand1_d  = bus.cmd_operand1;
          operand2_d  = bus.cmd_operand2;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        alu_enable_c = 1'b1;
        wait_cnt_d   = 4'(RESULT_LATENCY);
        state_d      = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        // Counter value 1 marks the edge on which the ALU output is valid.
        if (wait_cnt_q == 4'd1) begin
          rsp_data_d = bus.alu_result;
`ifdef ALU_ISSUE_ZFLAG_EN
          rsp_zero_d = (bus.alu_result == '0);
`endif
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command/response state register stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_select_q  <= '0;
      operation_q  <= '0;
      operand1_q   <= '0;
      operand2_q   <= '0;
      wait_cnt_q   <= '0;
      rsp_data_q   <= '0;
      done_count_q <= '0;
`ifdef ALU_ISSUE_ZFLAG_EN
      rsp_zero_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_select_q  <= op_select_d;
      operation_q  <= operation_d;
      operand1_q   <= operand1_d;
      operand2_q   <= operand2_d;
      wait_cnt_q   <= wait_cnt_d;
      rsp_data_q   <= rsp_data_d;
      done_count_q <= done_count_d;
`ifdef ALU_ISSUE_ZFLAG_EN
      rsp_zero_q   <= rsp_zero_d;
`endif
    end
  end

  // Ready is masked directly by reset so nothing is offered while it is held.
  assign bus.cmd_ready     = cmd_ready_c & ~reset;
  assign bus.alu_enable    = alu_enable_c;
  assign bus.alu_op_select = op_select_q;
  assign bus.alu_operation = operation_q;
  assign bus.alu_input1    = operand1_q;
  assign bus.alu_input2    = operand2_q;
  assign bus.rsp_valid     = rsp_valid_c;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.done_count    = done_count_q;
`ifdef ALU_ISSUE_ZFLAG_EN
  assign bus.rsp_zero      = rsp_zero_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance at RESULT_LATENCY=1 and one at 3, each fed by a small ALU model.
module tb_alu_issue_ctrl;
  localparam logic [2:0] ARITH_LOGIC = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if if1();
  alu_issue_ctrl_if if3();

  alu_issue_ctrl #(.RESULT_LATENCY(1)) u1 (.clock(clk), .reset(rst), .bus(if1.slave));
  alu_issue_ctrl #(.RESULT_LATENCY(3)) u3 (.clock(clk), .reset(rst), .bus(if3.slave));

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      default: return a | b;
    endcase
  endfunction

  // ALU models: result becomes valid RESULT_LATENCY cycles after the capture edge, garbage before that
  logic [31:0] pend1 = 32'hDEADBEEF;
  logic [31:0] pend3 = 32'hDEADBEEF;
  int age3 = 0;
  int en1 = 0;
  int cyc_n = 0;
  int hs_last3 = -1;
  int hs_prev3 = -1;
  int rv3_cnt = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (if1.alu_enable) begin
      pend1 <= alu_f(if1.alu_operation, if1.alu_input1, if1.alu_input2);
      en1   <= en1 + 1;
    end
    if (if3.alu_enable) begin
      pend3 <= alu_f(if3.alu_operation, if3.alu_input1, if3.alu_input2);
      age3  <= 0;
    end else begin
      age3  <= age3 + 1;
    end
    if (if3.cmd_valid && if3.cmd_ready) begin
      hs_prev3 <= hs_last3;
      hs_last3 <= cyc_n;
    end
    if (if3.rsp_valid) rv3_cnt <= rv3_cnt + 1;
  end

  assign if1.alu_result = pend1;
  assign if3.alu_result = (age3 >= 2) ? pend3 : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [2:0] sel, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (d == 1) begin
      if1.cmd_valid = v; if1.cmd_op_select = sel; if1.cmd_operation = op;
      if1.cmd_operand1 = a; if1.cmd_operand2 = b;
    end else begin
      if3.cmd_valid = v; if3.cmd_op_select = sel; if3.cmd_operation = op;
      if3.cmd_operand1 = a; if3.cmd_operand2 = b;
    end
  endtask

  function automatic logic rv(input int d);
    return (d == 1) ? if1.rsp_valid : if3.rsp_valid;
  endfunction

  // Counts falling edges from command drive until rsp_valid, dropping cmd_valid after the first
  task automatic wait_rsp(input int d, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (d == 1) if1.cmd_valid = 1'b0;
        else        if3.cmd_valid = 1'b0;
      end
    end while (!rv(d) && cyc < 50);
    chk("rsp_valid_seen", rv(d), 1'b1);
  endtask

  int cyc;
  int rv_base;

  initial begin
    drive(1, 1'b0, ARITH_LOGIC, OP_ADD, 32'h0, 32'h0);
    drive(3, 1'b0, ARITH_LOGIC, OP_ADD, 32'h0, 32'h0);
    if1.rsp_ready = 1'b0;
    if3.rsp_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_cmd_ready", if1.cmd_ready, 1'b0);
    chk("rst_rsp_valid", if1.rsp_valid, 1'b0);
    chk("rst_alu_enable", if1.alu_enable, 1'b0);
    chk("rst_done_count", if1.done_count, 16'h0);
    chk("rst_rsp_data", if1.rsp_data, 32'h0);
    chk("rst_alu_input1", if3.alu_input1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("cmd_ready_after_rst", if1.cmd_ready, 1'b1);

    // Basic: 5 + 3 at latency 1
    @(negedge clk);
    drive(1, 1'b1, ARITH_LOGIC, OP_ADD, 32'd5, 32'd3);
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    chk("basic_alu_enable", if1.alu_enable, 1'b1);
    chk("basic_alu_in1", if1.alu_input1, 32'd5);
    chk("basic_alu_in2", if1.alu_input2, 32'd3);
    chk("basic_alu_op", if1.alu_operation, OP_ADD);
    chk("basic_cmd_ready_issue", if1.cmd_ready, 1'b0);
    @(negedge clk);
    chk("basic_enable_drop", if1.alu_enable, 1'b0);
    chk("basic_rsp_valid_early", if1.rsp_valid, 1'b0);
    @(negedge clk);
    chk("basic_rsp_valid", if1.rsp_valid, 1'b1);
    chk("basic_rsp_data", if1.rsp_data, 32'h8);
    chk("basic_done_before", if1.done_count, 16'd0);
    @(negedge clk);
    chk("basic_rsp_valid_after", if1.rsp_valid, 1'b0);
    chk("basic_done_count", if1.done_count, 16'd1);
    chk("basic_cmd_ready_idle", if1.cmd_ready, 1'b1);
    chk("basic_enable_pulses", en1, 1);
    chk("basic_alu_in1_hold", if1.alu_input1, 32'd5);

    // Backpressure: 100 - 1 with consumer stalled for 4 cycles
    if1.rsp_ready = 1'b0;
    drive(1, 1'b1, 3'b010, OP_SUB, 32'd100, 32'd1);
    wait_rsp(1, cyc);
    chk("bp_latency", cyc, 3);
    chk("bp_rsp_data", if1.rsp_data, 32'h63);
    chk("bp_op_select", if1.alu_op_select, 3'b010);
    for (int i = 0; i < 4; i++) begin
      drive(1, (i % 2) == 0, ARITH_LOGIC, OP_ADD, 32'h1000 + i, 32'd1);
      @(negedge clk);
      chk("bp_rsp_valid", if1.rsp_valid, 1'b1);
      chk("bp_rsp_data_hold", if1.rsp_data, 32'h63);
      chk("bp_cmd_ready", if1.cmd_ready, 1'b0);
      chk("bp_done_hold", if1.done_count, 16'd1);
      chk("bp_alu_in1_hold", if1.alu_input1, 32'd100);
    end
    if1.cmd_valid = 1'b0;
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_valid_after", if1.rsp_valid, 1'b0);
    chk("bp_done_count", if1.done_count, 16'd2);

    // Latency 3: 0x10 + 0x20
    if3.rsp_ready = 1'b1;
    drive(3, 1'b1, ARITH_LOGIC, OP_ADD, 32'h10, 32'h20);
    wait_rsp(3, cyc);
    chk("lat3_cycles", cyc, 5);
    chk("lat3_rsp_data", if3.rsp_data, 32'h30);
    @(negedge clk);
    chk("lat3_done_count", if3.done_count, 16'd1);

    // Back-to-back with cmd_valid held high: accepts every 6 cycles
    drive(3, 1'b1, ARITH_LOGIC, OP_ADD, 32'd7, 32'd8);
    repeat (14) @(negedge clk);
    if3.cmd_valid = 1'b0;
    chk("b2b_spacing", hs_last3 - hs_prev3, 6);
    repeat (8) @(negedge clk);
    chk("b2b_done_count", if3.done_count, 16'd4);
    chk("b2b_rsp_data", if3.rsp_data, 32'd15);

    // Reset asserted asynchronously while waiting on the ALU
    drive(3, 1'b1, ARITH_LOGIC, OP_ADD, 32'h55, 32'h1);
    @(negedge clk);
    if3.cmd_valid = 1'b0;
    @(negedge clk);
    rv_base = rv3_cnt;
    #2 rst = 1'b1;
    #1;
    chk("rmw_rsp_valid", if3.rsp_valid, 1'b0);
    chk("rmw_cmd_ready", if3.cmd_ready, 1'b0);
    chk("rmw_alu_in1", if3.alu_input1, 32'h0);
    chk("rmw_rsp_data", if3.rsp_data, 32'h0);
    chk("rmw_done_count", if3.done_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rmw_cmd_ready_after", if3.cmd_ready, 1'b1);
    repeat (6) @(negedge clk);
    chk("rmw_no_response", rv3_cnt - rv_base, 0);
    drive(3, 1'b1, ARITH_LOGIC, OP_SUB, 32'd50, 32'd8);
    wait_rsp(3, cyc);
    chk("rmw_next_cycles", cyc, 5);
    chk("rmw_next_data", if3.rsp_data, 32'd42);
    @(negedge clk);
    chk("rmw_next_done", if3.done_count, 16'd1);

    // Wrap: preload the completion counter to 0xFFFF
    force u1.done_count_q = 16'hFFFF;
    @(negedge clk);
    release u1.done_count_q;
    #1 chk("wrap_preload", if1.done_count, 16'hFFFF);
    drive(1, 1'b1, ARITH_LOGIC, OP_ADD, 32'd2, 32'd2);
    wait_rsp(1, cyc);
    chk("wrap_rsp_data", if1.rsp_data, 32'd4);
    chk("wrap_hold", if1.done_count, 16'hFFFF);
    @(negedge clk);
    chk("wrap_done_count", if1.done_count, 16'h0000);

    // Zero result and non-zero result
    drive(1, 1'b1, ARITH_LOGIC, OP_SUB, 32'd7, 32'd7);
    wait_rsp(1, cyc);
    chk("z_sub_data", if1.rsp_data, 32'h0);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("z_sub_flag", if1.rsp_zero, 1'b1);
`endif
    @(negedge clk);
    drive(1, 1'b1, ARITH_LOGIC, OP_ADD, 32'd1, 32'd1);
    wait_rsp(1, cyc);
    chk("z_add_data", if1.rsp_data, 32'd2);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("z_add_flag", if1.rsp_zero, 1'b0);
`endif
    @(negedge clk);
    chk("z_done_count", if1.done_count, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter RESULT_LATENCY, default 1: cycles from the ALU capture edge to a valid alu_result; legal range 1-15.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_op_select  input  3  ALU unit select, passed through unchanged.
REQ-007 cmd_operation  input  3  ALU operation code, passed through unchanged.
REQ-008 cmd_operand1 / cmd_operand2  input  32 each  operands.
REQ-009 alu_enable  output  1  ALU capture strobe.
REQ-010 alu_op_select / alu_operation  output  3 each  driven to ALU.
REQ-011 alu_input1 / alu_input2  output  32 each  driven to ALU.
REQ-012 alu_result  input  32  ALU output.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_data  output  32  captured result.
REQ-016 done_count  output  16  completed responses, wraps.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, register all cmd_* fields, go ISSUE.
REQ-019 ISSUE: alu_enable=1 for exactly one cycle with registered fields on alu_*; go WAIT, load wait counter with RESULT_LATENCY.
REQ-020 WAIT: decrement counter each cycle; at the edge where counter equals 1, register alu_result into rsp_data and go RESP.
REQ-021 RESP: rsp_valid=1; rsp_data held stable until rsp_valid&rsp_ready; on handshake increment done_count and go IDLE.
REQ-022 cmd_ready=0 in ISSUE, WAIT, RESP; no new command is accepted in the cycle of a response handshake.
REQ-023 alu_input1/2, alu_operation, alu_op_select hold their values from ISSUE until the next accepted command.
REQ-024 alu_enable=0 in all states except ISSUE.
REQ-025 Latency: command handshake edge E0 -> rsp_valid high in cycle after edge E0+1+RESULT_LATENCY; throughput one command per 3+RESULT_LATENCY cycles with rsp_ready held high.
REQ-026 done_count wraps 16'hFFFF -> 16'h0000 without other effect.
REQ-027 cmd_* values while cmd_ready=0 are ignored.

Reset
REQ-028 Reset asserted: state IDLE, all registered outputs and rsp_data, done_count, wait counter = 0 immediately, independent of clock.
REQ-029 cmd_ready=0 while reset is asserted; 1 in the first cycle after deassertion.
REQ-030 Reset in ISSUE/WAIT/RESP abandons the operation; no response issued, done_count not incremented.

Configuration
REQ-031 Macro ALU_ISSUE_ZFLAG_EN defined: adds output rsp_zero (1 bit), registered with rsp_data, =1 when captured alu_result==0, reset 0, stable under backpressure.
REQ-032 Macro undefined: rsp_zero port absent; all other behaviour identical.

Verification
REQ-033 Basic: RESULT_LATENCY=1, cmd op_select ARITH_LOGIC, op 000, 5 and 3, ALU model returns 8 -> alu_enable one pulse, rsp_valid 3 cycles after handshake edge, rsp_data=32'h8, done_count=1.
REQ-034 Backpressure: rsp_ready low 4 cycles in RESP -> rsp_valid and rsp_data constant, cmd_ready=0, cmd_valid pulses ignored, done_count unchanged until handshake.
REQ-035 Latency: RESULT_LATENCY=3, model result valid 3 cycles after capture -> rsp_data correct, rsp_valid 5 cycles after handshake edge, back-to-back commands spaced 6 cycles.
REQ-036 Reset mid-WAIT: assert reset asynchronously -> outputs 0 same cycle, no rsp_valid, cmd_ready=1 cycle after deassertion, next command completes normally.
REQ-037 Wrap: preload 65535 completions -> next handshake gives done_count=0.
REQ-038 ZFLAG: with ALU_ISSUE_ZFLAG_EN, SUB 7-7 -> rsp_zero=1, rsp_data=0; ADD 1+1 -> rsp_zero=0.
